// File: rtl/sobel_pkg.sv
// Shared constants, FSM state type and border helper for the Sobel edge-map stages.
package sobel_pkg;
    localparam int PIX_W      = 8;
    localparam int COLS       = 8;
    localparam int ROWS       = 8;
    localparam int EDGE_CNT_W = 7;
    localparam int COL_W      = $clog2(COLS);
    localparam int ROW_W      = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_t;

    // Only the interior 6x6 carries a real gradient; the frame ring is forced to 0.
    function automatic logic is_border(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
        return (row == '0) || (row == ROW_W'(ROWS - 1)) || (col == '0) || (col == COL_W'(COLS - 1));
    endfunction
endpackage

// File: rtl/edge_map_packer_if.sv
// Pixel-in / row-word-out handshake bundle of the edge map packer.
interface edge_map_packer_if #(
    parameter int PIX_W = sobel_pkg::PIX_W,
    parameter int COLS  = sobel_pkg::COLS
);
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             pix_ready;
    logic             row_valid;
    logic [COLS-1:0]  row_data;
    logic             row_last;
    logic             row_ready;

    modport master (output pix_valid, pix_data, row_ready,
                    input  pix_ready, row_valid, row_data, row_last);
    modport slave  (input  pix_valid, pix_data, row_ready,
                    output pix_ready, row_valid, row_data, row_last);
endinterface

// File: rtl/edge_map_packer_row_fifo.sv
// Show-ahead synchronous FIFO for packed row words, with registered full/empty flags.
module row_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the array is tiny and drives row_data directly, so it is cleared to keep outputs defined after reset.
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_d;
            full    <= (count_d == CNT_W'(DEPTH));
            empty   <= (count_d == '0);
        end
    end
endmodule

// File: rtl/edge_map_packer.sv
// Binarises a raster stream of Sobel magnitudes, packs rows into words and queues them downstream.
module edge_map_packer #(
    parameter int PIX_W      = sobel_pkg::PIX_W,
    parameter int COLS       = sobel_pkg::COLS,
    parameter int ROWS       = sobel_pkg::ROWS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [PIX_W-1:0]                 thresh,
    edge_map_packer_if.slave                 bus,
    output logic [sobel_pkg::EDGE_CNT_W-1:0] edge_count,
    output logic                             frame_done,
    output logic                             busy
);
    import sobel_pkg::*;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [COLS-1:0]  word_q, word_now;
    logic [PIX_W-1:0] thr_q, thr_eff;
    logic             accept, edge_bit, row_end, frame_end, pop;
    logic             fifo_full, fifo_empty;
    logic [COLS:0]    head;

    assign bus.pix_ready = !reset && !fifo_full && (state_q != FLUSH);
    assign accept        = bus.pix_valid && bus.pix_ready;
    // The first pixel of a frame compares against the live threshold it is latching.
    assign thr_eff       = (state_q == IDLE) ? thresh : thr_q;
    assign edge_bit      = !is_border(row_q, col_q) && (bus.pix_data >= thr_eff);
    assign word_now      = word_q | (COLS'(edge_bit) << col_q);
    assign row_end       = accept && (col_q == COL_W'(COLS - 1));
    assign frame_end     = row_end && (row_q == ROW_W'(ROWS - 1));
    assign pop           = bus.row_valid && bus.row_ready;
    assign busy          = (state_q != IDLE);

    row_fifo #(.WIDTH(COLS + 1), .DEPTH(FIFO_DEPTH)) u_row_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (row_end),
        .push_data ({frame_end, word_now}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.row_valid = !fifo_empty;
    assign bus.row_data  = head[COLS-1:0];
    assign bus.row_last  = head[COLS];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = COLLECT;
            COLLECT: if (frame_end) state_d = FLUSH;
            FLUSH:   if (pop && bus.row_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            word_q     <= '0;
            thr_q      <= '0;
            edge_count <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_done <= (state_q == FLUSH) && pop && bus.row_last;
            if (accept) begin
                if (state_q == IDLE) begin
                    thr_q      <= thresh;
                    edge_count <= EDGE_CNT_W'(edge_bit);
                end else begin
                    edge_count <= edge_count + EDGE_CNT_W'(edge_bit);
                end
                if (row_end) begin
                    col_q  <= '0;
                    word_q <= '0;
                    row_q  <= frame_end ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q  <= col_q + COL_W'(1);
                    word_q <= word_now;
                end
            end
        end
    end
endmodule

// File: tb/tb_edge_map_packer.sv
// Self-checking bench: directed and randomised frames against a per-pixel edge-map model.
module tb_edge_map_packer;
    import sobel_pkg::*;

    localparam int NPIX = ROWS * COLS;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [PIX_W-1:0]      thresh;
    logic [EDGE_CNT_W-1:0] edge_count;
    logic                  frame_done;
    logic                  busy;

    edge_map_packer_if #(.PIX_W(PIX_W), .COLS(COLS)) bus ();

    edge_map_packer #(.PIX_W(PIX_W), .COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .thresh     (thresh),
        .bus        (bus),
        .edge_count (edge_count),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [PIX_W-1:0] frame [NPIX];
    logic [COLS:0] got [$];
    int            done_cnt, acc_cnt;
    int            valid_pct, ready_pct;
    bit            prev_stall = 0, prev_reset = 1;
    logic [COLS:0] prev_word;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Samples the handshakes with the inputs already driven, then advances one clock.
    task automatic tick();
        if (prev_stall && !prev_reset)
            check("hold", {bus.row_valid, bus.row_last, bus.row_data}, {1'b1, prev_word});
        prev_stall = bus.row_valid && !bus.row_ready;
        prev_word  = {bus.row_last, bus.row_data};
        prev_reset = reset;
        if (bus.pix_valid && bus.pix_ready) acc_cnt++;
        if (bus.row_valid && bus.row_ready) got.push_back({bus.row_last, bus.row_data});
        if (frame_done) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input logic [PIX_W-1:0] thr1, input logic [PIX_W-1:0] thr2,
                             input int chg_at, input bit stall);
        logic [COLS-1:0] exp_w [ROWS];
        int  exp_cnt = 0;
        int  cyc = 0;
        bit  hold = stall;
        bit  saw_busy = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                bit interior = (r > 0) && (r < ROWS - 1) && (c > 0) && (c < COLS - 1);
                exp_w[r][c] = interior && (frame[r * COLS + c] >= thr1);
                exp_cnt += int'(exp_w[r][c]);
            end
        end
        got.delete();
        done_cnt = 0;
        acc_cnt  = 0;
        while ((acc_cnt < NPIX || got.size() < ROWS || done_cnt == 0) && cyc < 3000) begin
            if (hold && cyc >= 60) begin
                check($sformatf("%s_stall_accepted", tag), acc_cnt, 4 * COLS);
                check($sformatf("%s_stall_pix_ready", tag), bus.pix_ready, 1'b0);
                check($sformatf("%s_stall_row_valid", tag), bus.row_valid, 1'b1);
                hold = 0;
            end
            bus.pix_valid = (acc_cnt < NPIX) && (stall || $urandom_range(99) < valid_pct);
            bus.pix_data  = (acc_cnt < NPIX) ? frame[acc_cnt] : '0;
            thresh        = (acc_cnt >= chg_at) ? thr2 : thr1;
            bus.row_ready = !hold && ($urandom_range(99) < ready_pct);
            if (busy) saw_busy = 1;
            tick();
            cyc++;
        end
        bus.pix_valid = 1'b0;
        bus.row_ready = 1'b0;
        check($sformatf("%s_words", tag), got.size(), ROWS);
        for (int r = 0; r < ROWS && r < got.size(); r++)
            check($sformatf("%s_row%0d", tag, r), got[r], {r == ROWS - 1, exp_w[r]});
        check($sformatf("%s_edge_count", tag), edge_count, exp_cnt);
        check($sformatf("%s_frame_done", tag), done_cnt, 1);
        check($sformatf("%s_busy_seen", tag), saw_busy, 1'b1);
        check($sformatf("%s_busy_end", tag), busy, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        thresh        = '0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.row_ready = 1'b0;
        valid_pct     = 100;
        ready_pct     = 100;
        tick();
        tick();
        check("rst_pix_ready", bus.pix_ready, 1'b0);
        check("rst_row_valid", bus.row_valid, 1'b0);
        check("rst_row_data", bus.row_data, 8'h00);
        check("rst_row_last", bus.row_last, 1'b0);
        check("rst_edge_count", edge_count, 7'd0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick();
        check("post_rst_pix_ready", bus.pix_ready, 1'b1);

        // All-255 frame with free-flowing handshakes.
        for (int i = 0; i < NPIX; i++) frame[i] = 8'd255;
        run_frame("ones", 8'd100, 8'd100, NPIX, 0);
        if (got.size() > 1) check("ones_row1_const", got[1][COLS-1:0], 8'h7E);

        // Checkerboard interior, border pixels high to exercise forcing.
        valid_pct = 70;
        ready_pct = 60;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                frame[r * COLS + c] = ((r + c) % 2 == 1) ? 8'd200 : 8'd50;
        for (int c = 0; c < COLS; c++) frame[c] = 8'd200;
        run_frame("checker", 8'd128, 8'd128, NPIX, 0);
        if (got.size() > 2) begin
            check("checker_row1_const", got[1][COLS-1:0], 8'h54);
            check("checker_row2_const", got[2][COLS-1:0], 8'h2A);
        end

        // Downstream stalled until the FIFO fills and input backpressure appears.
        ready_pct = 50;
        for (int i = 0; i < NPIX; i++) frame[i] = PIX_W'($urandom_range(255));
        run_frame("stall", 8'd128, 8'd128, NPIX, 1);

        // Threshold moves mid-frame; the first-pixel sample must govern the whole frame.
        valid_pct = 80;
        ready_pct = 80;
        for (int i = 0; i < NPIX; i++) frame[i] = 8'd100;
        run_frame("thr_change", 8'd10, 8'd250, 20, 0);

        // Equality counts as an edge; a bright border pixel stays 0.
        for (int i = 0; i < NPIX; i++) frame[i] = 8'd0;
        frame[1 * COLS + 1] = 8'd77;
        frame[0 * COLS + 3] = 8'd255;
        run_frame("boundary", 8'd77, 8'd77, NPIX, 0);
        if (got.size() > 1) check("boundary_row1_const", got[1][COLS-1:0], 8'h02);

        // Random frames and thresholds.
        for (int f = 0; f < 3; f++) begin
            logic [PIX_W-1:0] thr;
            thr = PIX_W'($urandom_range(255));
            valid_pct = 40 + 20 * f;
            ready_pct = 90 - 25 * f;
            for (int i = 0; i < NPIX; i++) frame[i] = PIX_W'($urandom_range(255));
            run_frame($sformatf("rand%0d", f), thr, PIX_W'($urandom_range(255)), 1 + f * 7, 0);
        end

        // Reset in the middle of a frame with words still queued.
        for (int i = 0; i < NPIX; i++) frame[i] = 8'd255;
        acc_cnt = 0;
        got.delete();
        thresh = 8'd100;
        bus.row_ready = 1'b0;
        for (int cyc = 0; cyc < 200 && acc_cnt < 30; cyc++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = frame[acc_cnt];
            tick();
        end
        bus.pix_valid = 1'b0;
        check("mid_accepted", acc_cnt, 30);
        check("mid_row_valid_before", bus.row_valid, 1'b1);
        reset = 1'b1;
        tick();
        check("mid_rst_row_valid", bus.row_valid, 1'b0);
        check("mid_rst_edge_count", edge_count, 7'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_pix_ready", bus.pix_ready, 1'b0);
        reset = 1'b0;
        tick();
        valid_pct = 100;
        ready_pct = 100;
        run_frame("after_rst", 8'd100, 8'd100, NPIX, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
